// File: rtl/fmt_iter_ctl.sv
// Sequencing controller for the iterative FP divide/sqrt datapath: format lookup,
// iteration counting and init/step enables. Optional macro FMT_ITER_EARLYTERM_EN.
module fmt_iter_ctl #(
    parameter int NE      = 15,
    parameter int LOGFLEN = 7,
    parameter int LOGR    = 2,
    parameter int GUARD   = 3,
    parameter int CNTW    = 6
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               StartValid,
    output logic               StartReady,
    input  logic [1:0]         Fmt,
    input  logic               SqrtIn,
    input  logic               SpecialCase,
    input  logic               Flush,
    input  logic               Stall,
    output logic               InitEn,
    output logic               IterEn,
    output logic               LastIter,
    output logic               Busy,
    output logic               SqrtOp,
    output logic [NE-2:0]      Bias,
    output logic [LOGFLEN-1:0] Nf,
    output logic               ResultValid,
    input  logic               ResultReady
);
    localparam int BW = NE - 1;
    localparam int SW = LOGFLEN + 1;
    localparam int SH = $clog2(LOGR);

    typedef enum logic [1:0] {IDLE, INIT, ITER, DONE} state_t;

    state_t             state_reg, state_next;
    logic [CNTW-1:0]    cnt_reg, cnt_next;
    logic [BW-1:0]      bias_reg, bias_lut;
    logic [LOGFLEN-1:0] nf_reg, nf_lut;
    logic               sqrt_reg;
    logic               special_reg;
    logic               accept;
    logic               kill;
    logic               iter_go;
    logic [SW-1:0]      n_sum;
    logic [CNTW-1:0]    n_init;

    always_comb begin
        bias_lut = '0;
        nf_lut   = '0;
        unique case (Fmt)
            2'd0: begin bias_lut = BW'(127);   nf_lut = LOGFLEN'(23);  end
            2'd1: begin bias_lut = BW'(1023);  nf_lut = LOGFLEN'(52);  end
            2'd2: begin bias_lut = BW'(15);    nf_lut = LOGFLEN'(10);  end
            2'd3: begin bias_lut = BW'(16383); nf_lut = LOGFLEN'(112); end
        endcase
    end

    // Sum is one bit wider than Nf so the Q-format numerator cannot wrap.
    assign n_sum  = {1'b0, nf_reg} + SW'(GUARD + LOGR);
    assign n_init = CNTW'(n_sum >> SH) - CNTW'(1);

    assign kill    = Flush || !reset_n;
    assign accept  = (state_reg == IDLE) && StartValid && !Flush;
    assign iter_go = (state_reg == ITER) && !Stall;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        InitEn      = 1'b0;
        IterEn      = 1'b0;
        LastIter    = 1'b0;
        ResultValid = 1'b0;
        unique case (state_reg)
            IDLE: if (StartValid) state_next = INIT;
            INIT: begin
                InitEn     = 1'b1;
                cnt_next   = n_init;
                state_next = ITER;
`ifdef FMT_ITER_EARLYTERM_EN
                if (special_reg) state_next = DONE;
`endif
            end
            ITER: begin
                IterEn = iter_go;
                if (iter_go) begin
                    if (cnt_reg == '0) begin
                        LastIter   = 1'b1;
                        state_next = DONE;
                    end else begin
                        cnt_next = cnt_reg - CNTW'(1);
                    end
                end
            end
            DONE: begin
                ResultValid = 1'b1;
                if (ResultReady) state_next = IDLE;
            end
        endcase
        // Flush (or reset) wins over every transition and silences the pulses.
        if (kill) begin
            state_next  = IDLE;
            InitEn      = 1'b0;
            IterEn      = 1'b0;
            LastIter    = 1'b0;
            ResultValid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            bias_reg    <= '0;
            nf_reg      <= '0;
            sqrt_reg    <= 1'b0;
            special_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                bias_reg    <= bias_lut;
                nf_reg      <= nf_lut;
                sqrt_reg    <= SqrtIn;
                special_reg <= SpecialCase;
            end
        end
    end

`ifndef FMT_ITER_EARLYTERM_EN
    logic unused_special;
    assign unused_special = special_reg;
`endif

    assign StartReady = (state_reg == IDLE);
    assign Busy       = (state_reg != IDLE);
    assign SqrtOp     = sqrt_reg;
    assign Bias       = bias_reg;
    assign Nf         = nf_reg;
endmodule

// File: tb/tb_fmt_iter_ctl.sv
// Self-checking bench for fmt_iter_ctl: directed vector table, hand sequences for
// flush/reset corners, and randomized ops checked against a transaction-level model.
module tb_fmt_iter_ctl;
    localparam int GUARD = 3;
    localparam int LOGR  = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        StartValid, StartReady;
    logic [1:0]  Fmt;
    logic        SqrtIn, SpecialCase, Flush, Stall;
    logic        InitEn, IterEn, LastIter, Busy, SqrtOp;
    logic [13:0] Bias;
    logic [6:0]  Nf;
    logic        ResultValid, ResultReady;

    always #5 clk = ~clk;

    fmt_iter_ctl #(.NE(15), .LOGFLEN(7), .LOGR(LOGR), .GUARD(GUARD), .CNTW(6)) dut (
        .clk(clk), .reset_n(reset_n), .StartValid(StartValid), .StartReady(StartReady),
        .Fmt(Fmt), .SqrtIn(SqrtIn), .SpecialCase(SpecialCase), .Flush(Flush), .Stall(Stall),
        .InitEn(InitEn), .IterEn(IterEn), .LastIter(LastIter), .Busy(Busy), .SqrtOp(SqrtOp),
        .Bias(Bias), .Nf(Nf), .ResultValid(ResultValid), .ResultReady(ResultReady)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int op_id = 0;

    typedef struct {
        logic [1:0] fmt;
        bit         sq;
        bit         sp;
        int         stall_pct;
        int         stall_at;   // 0 = none, else 3 forced stall cycles from this cycle
        int         rr_delay;
        int         flush_at;   // 0 = none
        int         exp_n;
        int         exp_bias;
        int         exp_nf;
    } vec_t;

    vec_t vecs[10];

    int nf_tab[4]   = '{23, 52, 10, 112};
    int bias_tab[4] = '{127, 1023, 15, 16383};

    function automatic int ref_n(input int nf);
        return (nf + 1 + GUARD + LOGR - 1) / LOGR;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL op%0d %s: got %0h expected %0h (t=%0t)", op_id, nm, act, exp, $time);
        end
    endtask

    // Cycle 0 = acceptance cycle; the model tracks phases by iteration counts only.
    task automatic run_op(input vec_t v);
        int  eff_n, iters, stalls, c, done_cnt, iter_seen, rv_first;
        bit  fin, flushed, st, rr;
        logic [5:0] exp_v, act_v;
        iters = 0; stalls = 0; c = 0; done_cnt = 0; iter_seen = 0; rv_first = -1;
        fin = 0; flushed = 0;
`ifdef FMT_ITER_EARLYTERM_EN
        eff_n = v.sp ? 0 : v.exp_n;
`else
        eff_n = v.exp_n;
`endif
        @(negedge clk);
        StartValid = 1'b1; Fmt = v.fmt; SqrtIn = v.sq; SpecialCase = v.sp;
        Flush = 1'b0; Stall = 1'($urandom_range(0, 1)); ResultReady = 1'($urandom_range(0, 1));
        #1;
        chk("accept_idle", int'({StartReady, Busy, InitEn, IterEn, ResultValid}), 'b10000);
        while (!fin) begin
            @(negedge clk);
            c++;
            StartValid  = 1'($urandom_range(0, 1));
            Fmt         = 2'($urandom_range(0, 3));
            SqrtIn      = 1'($urandom_range(0, 1));
            SpecialCase = 1'($urandom_range(0, 1));
            st = (v.stall_at > 0 && c >= v.stall_at && c < v.stall_at + 3) ||
                 (int'($urandom_range(0, 99)) < v.stall_pct);
            Stall = st;
            Flush = (c == v.flush_at);
            if (c >= 2 && iters >= eff_n) rr = (done_cnt >= v.rr_delay);
            else rr = 1'($urandom_range(0, 1));
            ResultReady = rr;
            #1;
            act_v = {StartReady, Busy, InitEn, IterEn, LastIter, ResultValid};
            if (IterEn) iter_seen++;
            if (ResultValid && rv_first < 0) rv_first = c;
            if (Flush) begin
                exp_v = 6'b010000; fin = 1; flushed = 1;
            end else if (c == 1) begin
                exp_v = 6'b011000;
            end else if (iters < eff_n) begin
                exp_v = {1'b0, 1'b1, 1'b0, !st, (!st && iters == eff_n - 1), 1'b0};
                if (st) stalls++; else iters++;
            end else begin
                exp_v = 6'b010001;
                done_cnt++;
                if (rr) fin = 1;
            end
            chk($sformatf("ctl_c%0d", c), int'(act_v), int'(exp_v));
            chk("bias", int'(Bias), v.exp_bias);
            chk("nf", int'(Nf), v.exp_nf);
            chk("sqrtop", int'(SqrtOp), int'(v.sq));
            if (c > 400) begin
                n_cmp++; n_bad++;
                $display("FAIL op%0d timeout: got no handshake after %0d cycles expected <= 400", op_id, c);
                fin = 1; flushed = 1;
            end
        end
        chk("iter_count", iter_seen, iters);
        if (!flushed) begin
            chk("iter_total", iter_seen, eff_n);
            chk("rv_latency", rv_first, 2 + eff_n + stalls);
        end else begin
            chk("flush_no_rv", rv_first, -1);
        end
        $display("op %0d fmt=%0d sqrt=%0d sc=%0d iters=%0d stalls=%0d rv_at=%0d flushed=%0d",
                 op_id, v.fmt, v.sq, v.sp, iter_seen, stalls, rv_first, flushed);
        op_id++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t r;
        reset_n = 1'b0; StartValid = 1'b0; Fmt = 2'd0; SqrtIn = 1'b0; SpecialCase = 1'b0;
        Flush = 1'b0; Stall = 1'b0; ResultReady = 1'b0;

        //           fmt  sq sp pct at rr fl  N   bias   nf
        vecs[0] = '{2'd1, 0, 0, 0, 0, 0, 0, 28, 1023,  52};   // D divide
        vecs[1] = '{2'd0, 0, 0, 0, 0, 0, 0, 14, 127,   23};   // back-to-back S
        vecs[2] = '{2'd1, 1, 0, 0, 0, 0, 0, 28, 1023,  52};   // D
        vecs[3] = '{2'd2, 0, 0, 0, 0, 0, 0, 7,  15,    10};   // H
        vecs[4] = '{2'd3, 1, 0, 0, 0, 0, 0, 58, 16383, 112};  // Q
        vecs[5] = '{2'd0, 1, 0, 0, 6, 0, 0, 14, 127,   23};   // S sqrt, 3 stalls
        vecs[6] = '{2'd2, 0, 0, 0, 0, 0, 5, 7,  15,    10};   // H flushed on 4th IterEn
        vecs[7] = '{2'd0, 0, 0, 0, 0, 0, 0, 14, 127,   23};   // S after flush
        vecs[8] = '{2'd1, 0, 1, 0, 0, 0, 0, 28, 1023,  52};   // D SpecialCase
        vecs[9] = '{2'd1, 0, 0, 0, 0, 5, 0, 28, 1023,  52};   // ResultReady low 5 cycles

        repeat (3) @(negedge clk);
        #1;
        chk("reset_ctl", int'({StartReady, Busy, InitEn, IterEn, LastIter, ResultValid}), 'b100000);
        chk("reset_bias", int'(Bias), 0);
        chk("reset_nf", int'(Nf), 0);
        chk("reset_sqrt", int'(SqrtOp), 0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) run_op(vecs[i]);

        // StartValid coincident with Flush in IDLE is dropped.
        @(negedge clk);
        StartValid = 1'b1; Flush = 1'b1; Fmt = 2'd3; Stall = 1'b0;
        #1;
        chk("flush_idle_ready", int'(StartReady), 1);
        @(negedge clk);
        StartValid = 1'b0; Flush = 1'b0;
        #1;
        chk("flush_idle_drop", int'({Busy, InitEn}), 0);
        $display("op %0d flush-in-idle start dropped busy=%0d", op_id, Busy);
        op_id++;

        // Reset mid-operation clears state and latched fields.
        @(negedge clk);
        StartValid = 1'b1; Fmt = 2'd1; SqrtIn = 1'b1;
        repeat (4) begin
            @(negedge clk);
            StartValid = 1'b0;
        end
        #1;
        chk("midop_iter", int'(IterEn), 1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midop_rst_pulses", int'({InitEn, IterEn, LastIter, ResultValid}), 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("midop_rst_state", int'({StartReady, Busy}), 'b10);
        chk("midop_rst_fields", int'({Bias, Nf, SqrtOp}), 0);
        $display("op %0d reset mid-op busy=%0d bias=%0d nf=%0d", op_id, Busy, Bias, Nf);
        op_id++;

        for (int k = 0; k < 30; k++) begin
            r.fmt       = 2'($urandom_range(0, 3));
            r.sq        = 1'($urandom_range(0, 1));
            r.sp        = 1'($urandom_range(0, 1));
            r.stall_pct = int'($urandom_range(0, 50));
            r.stall_at  = 0;
            r.rr_delay  = int'($urandom_range(0, 4));
            r.flush_at  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : 0;
            r.exp_nf    = nf_tab[r.fmt];
            r.exp_bias  = bias_tab[r.fmt];
            r.exp_n     = ref_n(r.exp_nf);
            run_op(r);
        end

        @(negedge clk);
        StartValid = 1'b0; Flush = 1'b0;
        #1;
        chk("final_idle", int'({StartReady, Busy}), 'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fmt_iter_ctl.md
# fmt_iter_ctl

Sequencing controller for the iterative FP divide/square-root datapath. Accepts one operation per handshake, latches the operand format, and looks up that format's exponent bias and fraction width. It then computes the format-dependent iteration count and drives the init and step enables of the radix-2^LOGR recurrence. Sits between FPU issue and the fdivsqrt datapath, and honours pipeline flush and stall.

## Interface
Parameters:
- NE, 15, exponent width of the widest format; the Bias output is NE-1 bits
- LOGFLEN, 7, width of the Nf output
- LOGR, 2, quotient bits retired per iteration (1 or 2)
- GUARD, 3, extra guard/round bits computed beyond Nf+1
- CNTW, 6, iteration counter width; must hold the Q-format count

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- StartValid  in  1  operation request
- StartReady  out  1  controller can accept a request; high only in IDLE
- Fmt  in  2  format: 0=S, 1=D, 2=H, 3=Q
- SqrtIn  in  1  1 = square root, 0 = divide
- SpecialCase  in  1  operand is NaN, Inf or zero, or divide-by-zero; qualified with StartValid
- Flush  in  1  kill the in-flight operation
- Stall  in  1  freeze iteration progress
- InitEn  out  1  one-cycle pulse loading the datapath residual/quotient registers
- IterEn  out  1  advance the recurrence one step
- LastIter  out  1  IterEn cycle is the final iteration
- Busy  out  1  state is not IDLE
- SqrtOp  out  1  latched SqrtIn
- Bias  out  NE-1  latched bias: S 127, D 1023, H 15, Q 16383
- Nf  out  LOGFLEN  latched fraction bits: S 23, D 52, H 10, Q 112
- ResultValid  out  1  result ready for writeback
- ResultReady  in  1  consumer accepts the result

## Operation
- States: IDLE, INIT, ITER, DONE.
- IDLE: StartReady=1. When StartValid, go to INIT and latch Fmt, SqrtIn, SpecialCase, Bias, Nf.
- INIT: InitEn=1 for exactly one cycle. Load the counter with N-1, where N = ceil((Nf+1+GUARD)/LOGR).
  - With LOGR=2, GUARD=3: S=14, D=28, H=7, Q=58.
  - Arithmetic uses unsigned width CNTW; the ceiling is computed as (Nf+GUARD+LOGR)>>log2(LOGR).
  - Next state is ITER, or DONE if early-terminated (see Configuration).
- ITER: IterEn = !Stall.
  - When IterEn and counter==0: LastIter=1, next state DONE.
  - Otherwise, on IterEn the counter decrements.
  - When Stall: counter holds, IterEn=0, LastIter=0.
- DONE: ResultValid=1, held until ResultReady. The cycle ResultValid&&ResultReady is seen, go to IDLE.
  - No same-cycle accept of a new request: StartReady rises the following cycle.
- Flush: synchronous, highest priority after reset, effective in any state.
  - Next state IDLE; InitEn, IterEn, LastIter and ResultValid are 0 in the flush cycle itself.
  - A StartValid coincident with Flush in IDLE is dropped.
- Stall has no effect in IDLE, INIT or DONE. DONE waits only on ResultReady.
- Latched Bias, Nf and SqrtOp are stable from INIT through DONE. They change only on acceptance.

## Timing
- Reset (reset_n=0 at a clk edge):
  - State IDLE, counter 0, StartReady=1.
  - InitEn, IterEn, LastIter, Busy and ResultValid are 0.
  - Bias=0, Nf=0, SqrtOp=0.
- Acceptance in cycle t: InitEn in t+1; IterEn in t+2 .. t+1+N with no stalls; ResultValid from t+2+N.
- Each stall cycle during ITER adds one cycle of latency.
- Early-terminate path: ResultValid at t+2.
- All outputs are Moore, decoded from registered state, except two: IterEn and LastIter are gated combinationally by Stall, and IterEn/LastIter/InitEn/ResultValid are forced to 0 by Flush.
- Reset mid-operation behaves as Flush and also clears the latched fields.

## Configuration
- FMT_ITER_EARLYTERM_EN defined: a latched SpecialCase=1 sends INIT directly to DONE. InitEn still pulses, IterEn is never asserted, and total latency is 2 cycles to ResultValid.
- Undefined: SpecialCase is ignored; every operation runs the full N iterations for its format.

## Test plan
- Reset, then D divide, Fmt=1, accepted at t=0: InitEn at 1; IterEn for cycles 2..29 (28 cycles); LastIter at 29; ResultValid at 30; Bias=1023, Nf=52.
- Back-to-back requests for each format, ResultReady tied high: iteration counts S 14, D 28, H 7, Q 58; Q Bias=16383, Nf=112; StartReady returns one cycle after the handshake.
- S sqrt with Stall high for 3 cycles mid-ITER: IterEn count still 14; ResultValid delayed 3 cycles, at t+19; SqrtOp=1 throughout.
- H op with Flush on the 4th IterEn cycle: IterEn=0 that cycle; IDLE next cycle; no ResultValid; a new S op then runs its full 14 iterations.
- SpecialCase=1 on a D op: with FMT_ITER_EARLYTERM_EN, ResultValid at t+2 with zero IterEn; without it, 28 iterations.
- ResultReady held low 5 cycles in DONE: ResultValid stays high and StartReady stays low; the StartValid pulse is ignored until return to IDLE.
